triangle_fetch: RTL and testbench
=================================

# triangle_fetch

Upstream feeder for `project_cal`. On a frame-start pulse it walks the mesh's triangle index ROM and fetches each triangle's three vertices from the vertex ROM. It presents the assembled triangle on `orig_triangle`, waits for the combinational projection to settle, and captures `proj_triangle`/`clip`. Unclipped screen-space triangles are handed to the rasterizer over a valid/ready handshake; clipped ones are dropped.

## Interface
Parameters:
- `WI`, 8: integer bits of a vertex coordinate.
- `WF`, 8: fraction bits of a vertex coordinate.
- `NUM_TRI`, 12: triangles per mesh (≥1).
- `NUM_VERT`, 8: vertices per mesh.
- `IDX_W`, `$clog2(NUM_VERT)`: vertex index width.
- `TRI_W`, `$clog2(NUM_TRI)`: triangle address width.
- `PROJ_LAT`, 2: settle cycles allowed for the projection path (≥1).

Ports:
- `Clk`, in, 1: system clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `frame_start`, in, 1: one-cycle request to process the mesh.
- `idx_addr`, out, TRI_W: index ROM address.
- `idx_data`, in, [2:0][IDX_W-1:0]: vertex indices of the triangle; synchronous ROM, 1-cycle latency.
- `vtx_addr`, out, IDX_W: vertex ROM address.
- `vtx_data`, in, [2:0][WI+WF-1:0]: x,y,z of the vertex; synchronous ROM, 1-cycle latency.
- `orig_triangle`, out, [2:0][2:0][WI+WF-1:0]: to the projection stage.
- `proj_triangle`, in, [2:0][1:0][9:0]: from the projection stage.
- `clip`, in, 1: from the projection stage.
- `tri_out`, out, [2:0][1:0][9:0]: captured screen triangle.
- `tri_valid`, out, 1: `tri_out` is valid.
- `tri_ready`, in, 1: the rasterizer accepts the triangle.
- `busy`, out, 1: high in any state other than IDLE.
- `frame_done`, out, 1: one-cycle pulse after the last triangle.
- `tri_count`, out, TRI_W+1: triangles emitted in the current frame.

## Operation
- **States:** IDLE, FETCH_IDX, WAIT_IDX, FETCH_VTX, PROJ, EMIT, NEXT, DONE.
- **IDLE:**
  - On `frame_start`: `tri_idx←0`, `tri_count←0`, go to FETCH_IDX.
  - Otherwise `frame_start` is ignored in every state other than IDLE.
- **FETCH_IDX:** `idx_addr=tri_idx`. Go to WAIT_IDX.
- **WAIT_IDX:** `idx_reg←idx_data`. Clear `v_cnt`. Go to FETCH_VTX.
- **FETCH_VTX:** lasts 4 cycles, `v_cnt` = 0..3.
  - For `v_cnt<3`: `vtx_addr=idx_reg[v_cnt]`.
  - For `v_cnt≥1`: `vtx_reg[v_cnt-1]←vtx_data`.
  - After `v_cnt=3`: clear `p_cnt`, go to PROJ.
- **`orig_triangle`:** driven from `vtx_reg`, so it is stable from PROJ until the next FETCH_VTX.
- **PROJ:** lasts PROJ_LAT cycles. In the last cycle:
  - `tri_out←proj_triangle` and `clip_reg←clip`.
  - If `clip` is set, go to NEXT; otherwise go to EMIT.
- **EMIT:**
  - `tri_valid=1`, and `tri_out` is held.
  - When `tri_ready=1`: `tri_count++`, go to NEXT.
- **NEXT:**
  - If `tri_idx==NUM_TRI-1`, go to DONE.
  - Otherwise `tri_idx++`, go to FETCH_IDX.
- **DONE:** `frame_done=1` for one cycle, then go to IDLE.
- **Width rules:** `tri_idx` is TRI_W bits and never wraps within a frame. `tri_count` is TRI_W+1 bits, so it cannot overflow.

## Timing
- **Reset values:** state IDLE; all registers 0. Therefore `idx_addr`, `vtx_addr`, `orig_triangle`, `tri_out`, `tri_valid`, `busy`, `frame_done` and `tri_count` all reset to 0.
- **Reset mid-operation:** returns to IDLE immediately. `tri_valid` drops with no handshake completion, and `frame_done` is not produced.
- **First triangle:** with `frame_start` sampled at edge 0 and `tri_ready` tied high, `tri_valid` first rises in cycle 7+PROJ_LAT (cycle 9 at default).
- **Per-triangle cost:**
  - Emitted triangle: 8+PROJ_LAT cycles, plus any backpressure cycles.
  - Clipped triangle: 7+PROJ_LAT cycles.
- **Handshake:**
  - A transfer occurs on a cycle with `tri_valid && tri_ready`.
  - `tri_valid` never deasserts without a transfer, except on reset.
  - `tri_out` is stable while `tri_valid` is high.
- **`tri_ready` outside EMIT:** asserted while `tri_valid=0`, it has no effect.
- **`frame_start` in DONE:** ignored; a new frame needs a pulse in IDLE.
- **`frame_done` vs last transfer:** `frame_done` asserts 2 cycles after the last triangle's transfer (NEXT, then DONE).

## Structure
- Shared package `render_pkg`:
  - `vertex3_t` (`[2:0][WI+WF-1:0]`), `tri3_t`, `scr_vertex_t` (`[1:0][9:0]`), `scr_tri_t`.
  - Screen constants 640/480.
  - `fetch_state_t` enum.
- Single module. Counters and the FSM are inline; no sub-module is warranted.

## Test plan
- **Full pass, no backpressure:**
  - Stimulus: 12-triangle cube, `clip` tied 0, `tri_ready=1`, single `frame_start`.
  - Response: 12 transfers, the first in cycle 9; `frame_done` exactly once at cycle 1+12·10; `tri_count=12`.
- **Clipping:**
  - Stimulus: projection model asserts `clip` for triangles 3 and 7.
  - Response: 10 transfers, in order 0,1,2,4,5,6,8,9,10,11; `tri_count=10`; frame length 12·10−2 cycles.
- **Backpressure:**
  - Stimulus: `tri_ready` low for 5 cycles during triangle 0's EMIT.
  - Response: `tri_valid` and `tri_out` are held unchanged for 5 cycles; exactly one transfer occurs when `tri_ready` rises.
- **Fetch addressing:**
  - Stimulus: index ROM entry 2 = {5,1,6}.
  - Response: `vtx_addr` sequence 5,1,6 on consecutive cycles; `orig_triangle` equals vertex ROM entries 5,1,6 in slots 0,1,2.
- **Ignored start:**
  - Stimulus: `frame_start` pulsed while busy, and again in the DONE cycle.
  - Response: no restart; `tri_idx` progression is unaffected.
- **Reset mid-frame:**
  - Stimulus: `Reset` asserted in EMIT of triangle 4.
  - Response: all outputs 0 immediately, IDLE, no `frame_done`; a subsequent `frame_start` restarts from triangle 0.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types for the render front end: vertex and triangle layouts,
// screen geometry and the triangle fetch state encoding.
package render_pkg;

   localparam int VTX_WI   = 8;
   localparam int VTX_WF   = 8;
   localparam int VTX_W    = VTX_WI + VTX_WF;

   localparam int SCR_W    = 640;
   localparam int SCR_H    = 480;
   localparam int SCR_BITS = $clog2((SCR_W > SCR_H) ? SCR_W : SCR_H);

   typedef logic [2:0][VTX_W-1:0]    vertex3_t;
   typedef vertex3_t [2:0]           tri3_t;
   typedef logic [1:0][SCR_BITS-1:0] scr_vertex_t;
   typedef scr_vertex_t [2:0]        scr_tri_t;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_FETCH_IDX,
      FS_WAIT_IDX,
      FS_FETCH_VTX,
      FS_PROJ,
      FS_EMIT,
      FS_NEXT,
      FS_DONE
   } fetch_state_t;

endpackage

// File: rtl/triangle_fetch.sv
// Walks the mesh index ROM, gathers three vertices per triangle, lets the
// projection settle and forwards unclipped screen triangles downstream.
module triangle_fetch
   import render_pkg::*;
#(
   parameter int WI       = VTX_WI,
   parameter int WF       = VTX_WF,
   parameter int NUM_TRI  = 12,
   parameter int NUM_VERT = 8,
   parameter int IDX_W    = $clog2(NUM_VERT),
   parameter int TRI_W    = $clog2(NUM_TRI),
   parameter int PROJ_LAT = 2
) (
   input  logic                                 Clk,
   input  logic                                 Reset,
   input  logic                                 frame_start,
   output logic [TRI_W-1:0]                     idx_addr,
   input  logic [2:0][IDX_W-1:0]                idx_data,
   output logic [IDX_W-1:0]                     vtx_addr,
   input  logic [2:0][WI+WF-1:0]                vtx_data,
   output logic [2:0][2:0][WI+WF-1:0]           orig_triangle,
   input  logic [2:0][1:0][SCR_BITS-1:0]        proj_triangle,
   input  logic                                 clip,
   output logic [2:0][1:0][SCR_BITS-1:0]        tri_out,
   output logic                                 tri_valid,
   input  logic                                 tri_ready,
   output logic                                 busy,
   output logic                                 frame_done,
   output logic [TRI_W:0]                       tri_count
);

   localparam int                PC_W     = (PROJ_LAT > 1) ? $clog2(PROJ_LAT) : 1;
   localparam logic [TRI_W-1:0]  LAST_TRI = TRI_W'(NUM_TRI - 1);
   localparam logic [PC_W-1:0]   LAST_P   = PC_W'(PROJ_LAT - 1);

   fetch_state_t                 state;
   fetch_state_t                 state_nxt;
   logic [TRI_W-1:0]             tri_idx;
   logic [2:0][IDX_W-1:0]        idx_reg;
   logic [1:0]                   v_cnt;
   logic [PC_W-1:0]              p_cnt;
   logic [2:0][2:0][WI+WF-1:0]   vtx_reg;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= FS_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FS_IDLE:      if (frame_start) state_nxt = FS_FETCH_IDX;
         FS_FETCH_IDX: state_nxt = FS_WAIT_IDX;
         FS_WAIT_IDX:  state_nxt = FS_FETCH_VTX;
         FS_FETCH_VTX: if (v_cnt == 2'd3) state_nxt = FS_PROJ;
         FS_PROJ:      if (p_cnt == LAST_P) state_nxt = clip ? FS_NEXT : FS_EMIT;
         FS_EMIT:      if (tri_ready) state_nxt = FS_NEXT;
         FS_NEXT:      state_nxt = (tri_idx == LAST_TRI) ? FS_DONE : FS_FETCH_IDX;
         FS_DONE:      state_nxt = FS_IDLE;
         default:      state_nxt = FS_IDLE;
      endcase
   end

   // The vertex ROM answers one cycle late, so slot v_cnt-1 is captured while
   // address v_cnt is being presented.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         tri_idx   <= '0;
         tri_count <= '0;
         idx_reg   <= '0;
         v_cnt     <= '0;
         p_cnt     <= '0;
         vtx_reg   <= '0;
         tri_out   <= '0;
      end else begin
         case (state)
            FS_IDLE: begin
               if (frame_start) begin
                  tri_idx   <= '0;
                  tri_count <= '0;
               end
            end
            FS_WAIT_IDX: begin
               idx_reg <= idx_data;
               v_cnt   <= '0;
            end
            FS_FETCH_VTX: begin
               v_cnt <= v_cnt + 2'd1;
               if (v_cnt != 2'd0) vtx_reg[v_cnt - 2'd1] <= vtx_data;
               if (v_cnt == 2'd3) p_cnt <= '0;
            end
            FS_PROJ: begin
               p_cnt <= p_cnt + 1'b1;
               if (p_cnt == LAST_P) tri_out <= proj_triangle;
            end
            FS_EMIT: begin
               if (tri_ready) tri_count <= tri_count + 1'b1;
            end
            FS_NEXT: begin
               if (tri_idx != LAST_TRI) tri_idx <= tri_idx + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      vtx_addr = '0;
      if (state == FS_FETCH_VTX && v_cnt != 2'd3) vtx_addr = idx_reg[v_cnt];
   end

   assign idx_addr      = tri_idx;
   assign orig_triangle = vtx_reg;
   assign tri_valid     = (state == FS_EMIT);
   assign busy          = (state != FS_IDLE);
   assign frame_done    = (state == FS_DONE);

endmodule

// File: tb/tb_triangle_fetch.sv
// Directed bench for triangle_fetch: ROM and projection models, a scoreboard
// of expected screen triangles and per-frame transfer/done timing checks.
module tb_triangle_fetch;
   import render_pkg::*;

   localparam int WI = 8;
   localparam int WF = 8;
   localparam int VW = WI + WF;
   localparam int NT = 12;
   localparam int NV = 8;
   localparam int IW = 3;
   localparam int TW = 4;
   localparam int PL = 2;

   logic                 Clk;
   logic                 Reset;
   logic                 frame_start;
   logic [TW-1:0]        idx_addr;
   logic [2:0][IW-1:0]   idx_data;
   logic [IW-1:0]        vtx_addr;
   logic [2:0][VW-1:0]   vtx_data;
   tri3_t                orig_triangle;
   scr_tri_t             proj_triangle;
   logic                 clip;
   scr_tri_t             tri_out;
   logic                 tri_valid;
   logic                 tri_ready;
   logic                 busy;
   logic                 frame_done;
   logic [TW:0]          tri_count;

   logic [2:0][IW-1:0]   idx_rom [16];
   logic [2:0][VW-1:0]   vtx_rom [NV];
   logic                 clip_en;

   logic [59:0]          exp_q[$];
   int                   exp_cyc[$];
   int                   xfer_q[$];
   int                   done_q[$];
   int                   exp_done;
   int                   tests_run = 0;
   int                   fails = 0;
   int                   edge_cnt = 0;
   int                   s = 0;
   scr_tri_t             held;

   triangle_fetch #(
      .WI(WI), .WF(WF), .NUM_TRI(NT), .NUM_VERT(NV),
      .IDX_W(IW), .TRI_W(TW), .PROJ_LAT(PL)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
      .idx_addr(idx_addr), .idx_data(idx_data),
      .vtx_addr(vtx_addr), .vtx_data(vtx_data),
      .orig_triangle(orig_triangle), .proj_triangle(proj_triangle), .clip(clip),
      .tri_out(tri_out), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .busy(busy), .frame_done(frame_done), .tri_count(tri_count)
   );

   // ---------------- clock / reset ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) edge_cnt <= edge_cnt + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- models ----------------
   always @(posedge Clk) begin
      idx_data <= idx_rom[idx_addr];
      vtx_data <= vtx_rom[vtx_addr];
   end

   function automatic tri3_t orig_of(input int k);
      tri3_t t;
      for (int v = 0; v < 3; v++) t[v] = vtx_rom[idx_rom[k][v]];
      return t;
   endfunction

   function automatic scr_tri_t proj_fn(input tri3_t t);
      scr_tri_t p;
      for (int v = 0; v < 3; v++)
         for (int c = 0; c < 2; c++)
            p[v][c] = t[v][c][VW-1 -: 10];
      return p;
   endfunction

   always_comb begin
      proj_triangle = proj_fn(orig_triangle);
      clip = clip_en && ((orig_triangle == orig_of(3)) || (orig_triangle == orig_of(7)));
   end

   function automatic int cyc();
      return edge_cnt - s + 1;
   endfunction

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge Clk) begin
      logic [59:0] e;
      if (!Reset && tri_valid && tri_ready) begin
         xfer_q.push_back(cyc());
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tri_out_sb", tri_out, e);
         end
      end
      if (frame_done) done_q.push_back(cyc());
   end

   // ---------------- driver tasks ----------------
   task automatic go(input int n);
      while (cyc() < n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic set_tri(input int k, input int a, input int b, input int c);
      idx_rom[k][0] = IW'(a);
      idx_rom[k][1] = IW'(b);
      idx_rom[k][2] = IW'(c);
   endtask

   task automatic start_frame(input bit clip_on, input int bp);
      int  t;
      bit  clipped;
      int  extra;
      clip_en = clip_on;
      xfer_q.delete();
      done_q.delete();
      exp_cyc.delete();
      exp_q.delete();
      t = 1;
      for (int k = 0; k < NT; k++) begin
         clipped = clip_on && (k == 3 || k == 7);
         extra   = (k == 0) ? bp : 0;
         if (clipped) t += 7 + PL;
         else begin
            exp_q.push_back(proj_fn(orig_of(k)));
            exp_cyc.push_back(t + 6 + PL + extra);
            t += 8 + PL + extra;
         end
      end
      exp_done = t;
      frame_start = 1'b1;
      @(posedge Clk);
      #1;
      frame_start = 1'b0;
      s = edge_cnt;
   endtask

   task automatic finish_frame(input string tag);
      go(exp_done + 3);
      chk({tag, "_xfer_count"}, xfer_q.size(), exp_cyc.size());
      for (int i = 0; i < exp_cyc.size(); i++)
         if (i < xfer_q.size()) chk({tag, "_xfer_cycle"}, xfer_q[i], exp_cyc[i]);
      chk({tag, "_done_pulses"}, done_q.size(), 1);
      if (done_q.size() > 0) chk({tag, "_done_cycle"}, done_q[0], exp_done);
      chk({tag, "_tri_count"}, tri_count, exp_cyc.size());
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_idx_addr"}, idx_addr, 0);
      chk({tag, "_vtx_addr"}, vtx_addr, 0);
      chk({tag, "_orig"}, orig_triangle, 0);
      chk({tag, "_tri_out"}, tri_out, 0);
      chk({tag, "_tri_valid"}, tri_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_tri_count"}, tri_count, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      Reset       = 1'b1;
      frame_start = 1'b0;
      tri_ready   = 1'b1;
      clip_en     = 1'b0;
      for (int i = 0; i < 16; i++) idx_rom[i] = '0;
      set_tri(0, 0, 1, 2);  set_tri(1, 0, 2, 3);  set_tri(2, 5, 1, 6);
      set_tri(3, 1, 2, 6);  set_tri(4, 4, 5, 6);  set_tri(5, 4, 6, 7);
      set_tri(6, 0, 4, 7);  set_tri(7, 0, 7, 3);  set_tri(8, 3, 2, 6);
      set_tri(9, 3, 6, 7);  set_tri(10, 0, 1, 5); set_tri(11, 0, 5, 4);
      for (int i = 0; i < NV; i++)
         for (int c = 0; c < 3; c++)
            vtx_rom[i][c] = VW'($urandom_range(1, 65535));

      repeat (2) @(posedge Clk);
      #1;
      check_zero("reset");
      Reset = 1'b0;
      @(posedge Clk);
      #1;

      // Full pass with fetch-address probing and ignored starts
      start_frame(1'b0, 0);
      go(23); chk("vtx_addr_0", vtx_addr, 5);
      go(24); chk("vtx_addr_1", vtx_addr, 1);
      go(25); chk("vtx_addr_2", vtx_addr, 6);
      chk("mid_tri_count", tri_count, 2);
      go(27); chk("orig_tri2", orig_triangle, orig_of(2));
      go(30);
      frame_start = 1'b1;
      @(posedge Clk);
      #1;
      frame_start = 1'b0;
      go(exp_done);
      chk("done_cycle_live", frame_done, 1);
      frame_start = 1'b1;
      @(posedge Clk);
      #1;
      frame_start = 1'b0;
      finish_frame("full");

      // Clipping of triangles 3 and 7
      start_frame(1'b1, 0);
      finish_frame("clip");
      clip_en = 1'b0;

      // Backpressure on triangle 0
      tri_ready = 1'b0;
      start_frame(1'b0, 5);
      go(9);
      chk("bp_valid_rise", tri_valid, 1);
      held = tri_out;
      chk("bp_first_tri", held, proj_fn(orig_of(0)));
      for (int c = 10; c <= 13; c++) begin
         go(c);
         chk("bp_valid_hold", tri_valid, 1);
         chk("bp_data_hold", tri_out, held);
      end
      go(14);
      tri_ready = 1'b1;
      finish_frame("bp");

      // Reset during triangle 4's EMIT
      start_frame(1'b0, 0);
      go(49);
      chk("pre_reset_valid", tri_valid, 1);
      Reset = 1'b1;
      #1;
      check_zero("midreset");
      chk("midreset_sb_left", exp_q.size(), 8);
      exp_q.delete();
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      repeat (20) @(posedge Clk);
      #1;
      chk("midreset_xfers", xfer_q.size(), 4);
      chk("midreset_no_done", done_q.size(), 0);
      chk("midreset_idle", busy, 0);

      // Restart after reset begins from triangle 0
      start_frame(1'b0, 0);
      go(9);
      chk("restart_first_tri", tri_out, proj_fn(orig_of(0)));
      finish_frame("restart");

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
